pc_return_stack: RTL
====================

// Module: pc_return_stack
// PURPOSE
//  - Hardware return-address stack plus next-PC source mux. Sits directly upstream of the program counter.
//  - DIN_OUT drives the PC's DIN. The control unit asserts PUSH on CALL/interrupt and POP on RET/RETI,
//    in the same cycle it asserts PC_LD.
//  - On CALL/interrupt it saves PC_COUNT+1. On RET/RETI it supplies the saved address. It also selects
//    branch targets and the interrupt vector.
// PARAMETERS
//  - WIDTH     10      address width; must equal the PC width
//  - DEPTH     8       stack entries (power of 2, >=2)
//  - INTR_VEC  10'h3FF interrupt vector address
// PORTS
//  - CLK         in   1                    system clock, rising edge
//  - RST         in   1                    synchronous, active-high reset
//  - PC_COUNT    in   WIDTH                current PC value (PC output)
//  - IR_ADDR     in   WIDTH                branch/call target field from instruction
//  - PC_MUX_SEL  in   2                    0=IR_ADDR 1=stack top 2=INTR_VEC 3=all zeros
//  - PUSH        in   1                    save PC_COUNT+1 at this edge
//  - POP         in   1                    discard top entry at this edge
//  - DIN_OUT     out  WIDTH                next-PC value to PC DIN (combinational)
//  - TOP         out  WIDTH                current top entry; 0 when empty
//  - COUNT       out  $clog2(DEPTH+1)      occupied entries
//  - EMPTY       out  1                    COUNT==0
//  - FULL        out  1                    COUNT==DEPTH
//  - OVF         out  1                    sticky: push attempted while full
//  - UNF         out  1                    sticky: pop attempted while empty
// BEHAVIOUR
//  - Reset:
//    - RST has priority over PUSH/POP.
//    - Next edge: COUNT=0, all entries=0, OVF=UNF=0. Hence EMPTY=1, FULL=0, TOP=0.
//  - Mux: DIN_OUT is a combinational function of PC_MUX_SEL and its inputs. Select 1 outputs TOP as it
//    was before the edge, so a RET loads the pre-pop top while the pop commits on the same edge.
//  - Push value: (PC_COUNT+1) mod 2^WIDTH. PC_COUNT=all-ones stores 0.
//  - Latency: push/pop commit at the rising edge. TOP and COUNT reflect the result the following cycle.
//  - Storage: top pointer TP, modulo DEPTH. TOP = entry[TP-1] when COUNT>0.
//  - PUSH only, not full: entry[TP]<=PC+1; TP++; COUNT++.
//  - PUSH only, full: OVF<=1; handling per CONFIGURATION.
//  - POP only, not empty: TP--; COUNT--. The popped entry is not cleared.
//  - POP only, empty: UNF<=1; TP and COUNT unchanged.
//  - PUSH and POP together, COUNT>0: replace top entry with PC+1. COUNT unchanged; no flag, even when full.
//  - PUSH and POP together, empty: behaves as PUSH only and sets UNF<=1.
//  - OVF/UNF stay set until RST. Neither flag blocks subsequent operations.
//  - RST during any operation: reset wins; the in-flight push/pop is discarded.
// CONFIGURATION
//  - Macro RSTACK_WRAP_EN.
//  - Defined: push on full overwrites the oldest entry (circular). entry[TP]<=PC+1; TP++; COUNT stays
//    DEPTH; OVF<=1. Subsequent pops return the newest DEPTH entries.
//  - Undefined: push on full is dropped. Storage, TP and COUNT unchanged; OVF<=1.
// TESTING
//  - Reset, then idle -> EMPTY=1 COUNT=0 TOP=0 OVF=UNF=0. SEL=2 gives DIN_OUT=0x3FF; SEL=3 gives 0.
//  - PUSH @PC=0x010, PUSH @PC=0x025 -> TOP=0x026 COUNT=2. POP -> TOP=0x011. POP -> EMPTY=1.
//  - SEL=1, POP=1 with TOP=0x026 -> DIN_OUT=0x026 in that cycle; next cycle TOP=0x011.
//  - PUSH @PC=0x3FF -> TOP=0x000 (wrap).
//  - 8 pushes @PC=0..7, then PUSH @PC=0x020:
//    - without macro: OVF=1 COUNT=8 TOP=0x008;
//    - with RSTACK_WRAP_EN: TOP=0x021; 8 pops yield 0x021,0x008..0x002, then EMPTY.
//  - POP while empty -> UNF=1, COUNT=0; UNF holds through later pushes until RST.
//  - COUNT=3, PUSH+POP @PC=0x040 -> COUNT=3, TOP=0x041, no flags.

Source files
------------

// File: rtl/pc_return_stack.sv
// Return-address stack with next-PC source mux, feeding the program counter's DIN.
// Define RSTACK_WRAP_EN to make a push on a full stack overwrite the oldest entry.
module pc_return_stack #(
   parameter int unsigned     WIDTH    = 10,
   parameter int unsigned     DEPTH    = 8,
   parameter logic [WIDTH-1:0] INTR_VEC = 10'h3FF
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic [WIDTH-1:0]           PC_COUNT,
   input  logic [WIDTH-1:0]           IR_ADDR,
   input  logic [1:0]                 PC_MUX_SEL,
   input  logic                       PUSH,
   input  logic                       POP,
   output logic [WIDTH-1:0]           DIN_OUT,
   output logic [WIDTH-1:0]           TOP,
   output logic [$clog2(DEPTH+1)-1:0] COUNT,
   output logic                       EMPTY,
   output logic                       FULL,
   output logic                       OVF,
   output logic                       UNF
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    tp_q, tp_d, tp_m1, wr_idx;
   logic [CW-1:0]    count_q, count_d;
   logic             ovf_q, ovf_d, unf_q, unf_d, wr_en;
   logic [WIDTH-1:0] push_val;
   logic             empty, full;

   assign tp_m1    = tp_q - PW'(1);
   assign push_val = PC_COUNT + WIDTH'(1);
   assign empty    = (count_q == '0);
   assign full     = (count_q == CW'(DEPTH));

   assign TOP   = empty ? '0 : mem_q[tp_m1];
   assign COUNT = count_q;
   assign EMPTY = empty;
   assign FULL  = full;
   assign OVF   = ovf_q;
   assign UNF   = unf_q;

   // Select 1 uses the pre-edge top so a RET loads it while its pop commits.
   always_comb begin
      DIN_OUT = '0;
      case (PC_MUX_SEL)
         2'd0:    DIN_OUT = IR_ADDR;
         2'd1:    DIN_OUT = TOP;
         2'd2:    DIN_OUT = INTR_VEC;
         default: DIN_OUT = '0;
      endcase
   end

   always_comb begin
      tp_d    = tp_q;
      count_d = count_q;
      ovf_d   = ovf_q;
      unf_d   = unf_q;
      wr_en   = 1'b0;
      wr_idx  = tp_q;
      if (PUSH && POP) begin
         if (empty) begin
            wr_en   = 1'b1;
            tp_d    = tp_q + PW'(1);
            count_d = count_q + CW'(1);
            unf_d   = 1'b1;
         end else begin
            wr_en  = 1'b1;
            wr_idx = tp_m1;
         end
      end else if (PUSH) begin
         if (full) begin
            ovf_d = 1'b1;
`ifdef RSTACK_WRAP_EN
            wr_en = 1'b1;
            tp_d  = tp_q + PW'(1);
`endif
         end else begin
            wr_en   = 1'b1;
            tp_d    = tp_q + PW'(1);
            count_d = count_q + CW'(1);
         end
      end else if (POP) begin
         if (empty) begin
            unf_d = 1'b1;
         end else begin
            tp_d    = tp_m1;
            count_d = count_q - CW'(1);
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         tp_q    <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         tp_q    <= tp_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
         if (wr_en) mem_q[wr_idx] <= push_val;
      end
   end

endmodule
